pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// PLL reset sequencer: holds the PLL in reset, qualifies lock, then releases the downstream reset.
// Define PLL_SEQ_LOSS_COUNT_EN to build the saturating lock-loss counter on LOSS_CNT.
module pll_reset_sequencer #(
   parameter int unsigned HOLD_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic       REFERENCECLK,
   input  logic       RESET,
   input  logic       LOCK,
   input  logic       RETRY,
   output logic       PLL_RESETB,
   output logic       SYS_RESET_N,
   output logic       READY,
   output logic       FAULT,
   output logic [7:0] LOSS_CNT
);

   // The shared counter only ever reaches (largest length - 1), so clog2 of that length suffices.
   localparam int unsigned MAX_AB  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [RW-1:0] retry_cnt;
   logic [RW-1:0] retry_nxt;
   logic          lock_meta;
   logic          lock_s;

   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= LOCK;
         lock_s    <= lock_meta;
      end
   end

   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         state     <= S_HOLD;
         cnt       <= '0;
         retry_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
      end
   end

   // RETRY is a single-cycle pulse sampled on the clock edge; it only matters in FAULT.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      retry_nxt = retry_cnt;
      case (state)
         S_HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = S_SETTLE;
               cnt_nxt   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               cnt_nxt = '0;
               if (retry_cnt < RETRY_LIMIT) begin
                  retry_nxt = retry_cnt + 1'b1;
                  state_nxt = S_HOLD;
               end else begin
                  state_nxt = S_FAULT;
               end
            end
         end
         S_SETTLE: begin
            // A lock glitch restarts qualification and the lock timeout.
            if (!lock_s) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end
         end
         S_RUN: begin
            cnt_nxt = '0;
            if (!lock_s) begin
               state_nxt = S_HOLD;
            end
         end
         S_FAULT: begin
            cnt_nxt = '0;
            if (RETRY) begin
               state_nxt = S_HOLD;
               retry_nxt = '0;
            end
         end
         default: begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         PLL_RESETB  <= 1'b0;
         SYS_RESET_N <= 1'b0;
         READY       <= 1'b0;
         FAULT       <= 1'b0;
      end else begin
         PLL_RESETB  <= (state_nxt != S_HOLD) && (state_nxt != S_FAULT);
         SYS_RESET_N <= (state_nxt == S_RUN);
         READY       <= (state_nxt == S_RUN);
         FAULT       <= (state_nxt == S_FAULT);
      end
   end

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic loss_evt;

   assign loss_evt = (state == S_RUN) && !lock_s;

   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         LOSS_CNT <= 8'h00;
      end else if (loss_evt && (LOSS_CNT != 8'hFF)) begin
         LOSS_CNT <= LOSS_CNT + 8'd1;
      end
   end
`else
   assign LOSS_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
// Bench for pll_reset_sequencer: vector tables, hand-written corner sequences and
// randomized LOCK/RETRY traffic checked against a countdown-based reference model.
module tb_pll_reset_sequencer;

   localparam int HOLD    = 4;
   localparam int TIMEOUT = 20;
   localparam int STABLE  = 8;
   localparam int MAXR    = 2;
`ifdef PLL_SEQ_LOSS_COUNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   localparam int PH_HOLD   = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_SETTLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAULT  = 4;

   typedef struct {
      bit lock;
      bit retry;
      bit pll;
      bit sys;
      bit rdy;
      bit flt;
   } vec_t;
   typedef vec_t vec_q_t[$];

   logic       clk;
   logic       rst_n;
   logic       lock;
   logic       retry;
   logic       pll_resetb;
   logic       sys_reset_n;
   logic       ready;
   logic       fault;
   logic [7:0] loss_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_phase;
   int m_left;
   int m_attempts;
   int m_loss;
   bit ls_q[$];

   pll_reset_sequencer #(
      .HOLD_CYCLES  (HOLD),
      .LOCK_TIMEOUT (TIMEOUT),
      .STABLE_CYCLES(STABLE),
      .MAX_RETRIES  (MAXR)
   ) dut (
      .REFERENCECLK(clk),
      .RESET       (rst_n),
      .LOCK        (lock),
      .RETRY       (retry),
      .PLL_RESETB  (pll_resetb),
      .SYS_RESET_N (sys_reset_n),
      .READY       (ready),
      .FAULT       (fault),
      .LOSS_CNT    (loss_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // reference model: phase lengths as countdowns, synchronizer as a 2-deep queue
   task automatic model_reset();
      m_phase    = PH_HOLD;
      m_left     = HOLD;
      m_attempts = 0;
      m_loss     = 0;
      ls_q.delete();
      ls_q.push_back(1'b0);
      ls_q.push_back(1'b0);
   endtask

   task automatic model_edge(input bit l, input bit r);
      bit ls;
      ls = ls_q.pop_front();
      ls_q.push_back(l);
      case (m_phase)
         PH_HOLD: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = PH_WAIT;
               m_left  = TIMEOUT;
            end
         end
         PH_WAIT: begin
            if (ls) begin
               m_phase = PH_SETTLE;
               m_left  = STABLE;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  if (m_attempts < MAXR) begin
                     m_attempts++;
                     m_phase = PH_HOLD;
                     m_left  = HOLD;
                  end else begin
                     m_phase = PH_FAULT;
                  end
               end
            end
         end
         PH_SETTLE: begin
            if (!ls) begin
               m_phase = PH_WAIT;
               m_left  = TIMEOUT;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_phase    = PH_RUN;
                  m_attempts = 0;
               end
            end
         end
         PH_RUN: begin
            if (!ls) begin
               m_phase = PH_HOLD;
               m_left  = HOLD;
               if (m_loss < 255) m_loss++;
            end
         end
         default: begin
            if (r) begin
               m_phase    = PH_HOLD;
               m_left     = HOLD;
               m_attempts = 0;
            end
         end
      endcase
   endtask

   // driver tasks
   task automatic check_outs(input string name, input bit e_pll, input bit e_sys,
                             input bit e_rdy, input bit e_flt, input logic [7:0] e_loss);
      logic [11:0] got;
      logic [11:0] exp;
      got = {pll_resetb, sys_reset_n, ready, fault, loss_cnt};
      exp = {e_pll, e_sys, e_rdy, e_flt, e_loss};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got pll_resetb=%b sys_reset_n=%b ready=%b fault=%b loss=%0d, expected %b %b %b %b %0d",
                  name, pll_resetb, sys_reset_n, ready, fault, loss_cnt,
                  e_pll, e_sys, e_rdy, e_flt, e_loss);
      end
   endtask

   task automatic check_model(input string name);
      check_outs(name, (m_phase != PH_HOLD) && (m_phase != PH_FAULT), m_phase == PH_RUN,
                 m_phase == PH_RUN, m_phase == PH_FAULT, LOSS_EN ? 8'(m_loss) : 8'd0);
   endtask

   task automatic step(input bit l, input bit r);
      lock  = l;
      retry = r;
      @(posedge clk);
      model_edge(l, r);
      #1;
   endtask

   // Asserts reset away from an edge and checks outputs clear without any clock edge.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #2;
      check_outs({tag, "_async"}, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      model_reset();
      lock  = 1'b0;
      retry = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs({tag, "_held"}, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 40) begin
         step(1'b1, 1'b0);
         n++;
      end
      checks++;
      if (!ready) begin
         failures++;
         $display("FAIL %s: READY=0 after %0d cycles, expected 1", tag, n);
      end
   endtask

   task automatic run_table(input string tag, input vec_q_t tab);
      for (int i = 0; i < tab.size(); i++) begin
         step(tab[i].lock, tab[i].retry);
         check_outs($sformatf("%s[%0d]", tag, i + 1), tab[i].pll, tab[i].sys,
                    tab[i].rdy, tab[i].flt, 8'd0);
      end
   endtask

   initial begin
      vec_q_t tab_a;
      vec_q_t tab_b;
      bit     cur;
      int     run_len;
      bit     long_run;

      // Edge k is the k-th clock edge after reset release; LOCK rises before edge 11.
      for (int k = 1; k <= 26; k++)
         tab_a.push_back('{lock: (k >= 11), retry: 1'b0, pll: (k >= 4),
                           sys: (k >= 21), rdy: (k >= 21), flt: 1'b0});
      // LOCK never rises: three 4-cycle holds separated by 20-cycle waits, then FAULT.
      for (int k = 1; k <= 100; k++)
         tab_b.push_back('{lock: 1'b0, retry: 1'b0,
                           pll: ((k >= 4) && (k < 24)) || ((k >= 28) && (k < 48)) || ((k >= 52) && (k < 72)),
                           sys: 1'b0, rdy: 1'b0, flt: (k >= 72)});

      rst_n = 1'b0;
      lock  = 1'b0;
      retry = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // power-up lock and release timing
      apply_reset("por");
      run_table("lock_at_10", tab_a);

      // RETRY in RUN has no effect
      step(1'b1, 1'b1);
      check_outs("run_retry_0", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i <= 2; i++) begin
         step(1'b1, 1'b0);
         check_outs($sformatf("run_retry_%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      end

      // lock loss in RUN: HOLD on the third edge, with RETRY coinciding
      step(1'b0, 1'b0);
      check_outs("loss_d1", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0);
      check_outs("loss_d2", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b1);
      check_outs("loss_d3", 1'b0, 1'b0, 1'b0, 1'b0, LOSS_EN ? 8'd1 : 8'd0);
      wait_ready("relock");
      check_outs("relock_run", 1'b1, 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);

      // no lock at all: retries then FAULT, held steady
      apply_reset("nolock");
      run_table("nolock", tab_b);

      // RETRY from FAULT with a PLL-like LOCK: low while held in reset, high once released
      step(1'b1, 1'b1);
      check_outs("fault_retry_t1", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int t = 2; t <= 17; t++) begin
         step(t >= 6, 1'b0);
         check_outs($sformatf("fault_retry_t%0d", t), t >= 5, t >= 16, t >= 16, 1'b0, 8'd0);
      end

      // one-cycle LOCK glitch five cycles into SETTLE
      apply_reset("glitch");
      repeat (6) step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      check_outs("glitch_settle", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0);
      for (int j = 1; j <= 11; j++) begin
         step(1'b1, 1'b0);
         check_outs($sformatf("glitch_r%0d", j), 1'b1, j == 11, j == 11, 1'b0, 8'd0);
      end

      // reset asserted mid-SETTLE
      apply_reset("pre_settle");
      repeat (8) step(1'b1, 1'b0);
      check_outs("mid_settle", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      apply_reset("settle_rst");

      // saturate the loss counter, then reset mid-RUN
      wait_ready("sat_first");
      for (int i = 0; i < 256; i++) begin
         repeat (3) step(1'b0, 1'b0);
         wait_ready($sformatf("sat_%0d", i));
      end
      check_outs("sat_255", 1'b1, 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd255 : 8'd0);
      apply_reset("run_rst");

      // randomized traffic against the reference model
      run_len = 0;
      cur     = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (run_len == 0) begin
            long_run = ($urandom_range(0, 9) == 0);
            if (long_run) begin
               cur     = 1'b0;
               run_len = $urandom_range(60, 120);
            end else begin
               cur     = ($urandom_range(0, 9) < 7);
               run_len = $urandom_range(1, 25);
            end
         end
         run_len--;
         step(cur, $urandom_range(0, 15) == 0);
         check_model($sformatf("rand_%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
